// File: rtl/rv32_imem_fetch.sv
// Instruction fetch front end: owns the PC, drives the synchronous BRAM read port
// and hides its one-cycle latency behind a 2-entry skid FIFO feeding decode.
module rv32_imem_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          IMEM_AW  = 13
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_rdaddress,
    input  logic [31:0]        imem_q,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc
);

    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        inflight_q;

    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_pc_q    [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;

    // Occupancy counts queued words plus the one still in the BRAM pipe, net of
    // this cycle's pop, so an issue is only allowed when its word is sure to fit.
    always_comb begin
        pop         = 1'b0;
        push        = 1'b0;
        issue       = 1'b0;
        occupancy   = 3'd0;
        instr_valid = (count_q != 2'd0);
        pop         = instr_valid & instr_ready;
        push        = inflight_q & ~redirect_valid;
        occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue       = fetch_en & ~redirect_valid & (occupancy <= 3'd1);
    end

    assign imem_rdaddress = pc_q[IMEM_AW+1:2];
    assign instr          = instr_valid ? fifo_instr_q[rd_ptr_q] : 32'h0000_0000;
    assign instr_pc       = instr_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0000_0000;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= PC_RESET;
            req_pc_q   <= 32'h0000_0000;
            inflight_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_pc & 32'hFFFF_FFFC;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q     <= pc_q + 32'd4;
                req_pc_q <= pc_q;
            end
        end
    end

    // A redirect wipes the queue outright; a pop racing it is simply lost.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_instr_q[i] <= 32'h0000_0000;
                fifo_pc_q[i]    <= 32'h0000_0000;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (redirect_valid) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_instr_q[wr_ptr_q] <= imem_q;
                fifo_pc_q[wr_ptr_q]    <= req_pc_q;
                wr_ptr_q               <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_imem_fetch.sv
// Bench for rv32_imem_fetch: a synchronous BRAM model plus a program-order
// reference that knows only "next expected PC", driven by directed and random traffic.
module tb_rv32_imem_fetch;

    localparam logic [31:0] PC_RESET = 32'h0000_0000;
    localparam int          IMEM_AW  = 13;

    logic               clock;
    logic               rst_n;
    logic               fetch_en;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic [IMEM_AW-1:0] imem_rdaddress;
    logic [31:0]        imem_q;
    logic               instr_valid;
    logic               instr_ready;
    logic [31:0]        instr;
    logic [31:0]        instr_pc;

    int checks;
    int errors;
    int deliveries;

    logic [31:0]        exp_pc;
    logic               prev_redirect;
    logic               prev_stall;
    logic [31:0]        prev_instr;
    logic [31:0]        prev_pc;
    logic [IMEM_AW-1:0] held_addr;
    logic [31:0]        pc_reset_v;

    rv32_imem_fetch #(
        .PC_RESET (PC_RESET),
        .IMEM_AW  (IMEM_AW)
    ) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_rdaddress (imem_rdaddress),
        .imem_q         (imem_q),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] memword(input logic [IMEM_AW-1:0] a);
        return 32'h1000_0000 + {{(32-IMEM_AW){1'b0}}, a};
    endfunction

    // Synchronous read port: data for the address seen at an edge appears after it.
    always @(posedge clock) begin
        imem_q <= memword(imem_rdaddress);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // One cycle: sample at the falling edge, check what the previous cycle promised,
    // drive new inputs and advance the program-order model on accept or redirect.
    task automatic applyStimulus(input logic en, input logic rdy, input logic rv,
                                 input logic [31:0] rpc);
        logic [31:0] want_pc;
        @(negedge clock);
        if (prev_redirect) checkOutput("flush_after_redirect", {31'b0, instr_valid}, 32'd0);
        if (prev_stall) begin
            checkOutput("stall_valid", {31'b0, instr_valid}, 32'd1);
            checkOutput("stall_instr", instr, prev_instr);
            checkOutput("stall_pc", instr_pc, prev_pc);
        end
        fetch_en       = en;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rv) begin
            exp_pc = {rpc[31:2], 2'b00};
        end else if (instr_valid && rdy) begin
            want_pc = exp_pc;
            checkOutput("deliver_pc", instr_pc, want_pc);
            checkOutput("deliver_instr", instr, memword(want_pc[IMEM_AW+1:2]));
            exp_pc = exp_pc + 32'd4;
            deliveries++;
        end
        prev_redirect = rv;
        prev_stall    = instr_valid && !rdy && !rv;
        prev_instr    = instr;
        prev_pc       = instr_pc;
    endtask

    task automatic clearModel();
        exp_pc        = pc_reset_v;
        prev_redirect = 1'b0;
        prev_stall    = 1'b0;
        prev_instr    = 32'd0;
        prev_pc       = 32'd0;
    endtask

    initial begin
        logic        en;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        int          start;

        checks         = 0;
        errors         = 0;
        deliveries     = 0;
        pc_reset_v     = PC_RESET;
        fetch_en       = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        rst_n          = 1'b1;
        clearModel();
        #1 rst_n = 1'b0;

        repeat (3) @(negedge clock);
        checkOutput("reset_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("reset_instr", instr, 32'd0);
        checkOutput("reset_pc", instr_pc, 32'd0);
        checkOutput("reset_addr", {19'b0, imem_rdaddress}, {19'b0, pc_reset_v[IMEM_AW+1:2]});

        // Release and stream with decode always ready.
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        rst_n       = 1'b1;
        applyStimulus(1, 1, 0, 0);
        checkOutput("first_latency_low", {31'b0, instr_valid}, 32'd0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("first_latency_high", {31'b0, instr_valid}, 32'd1);
        checkOutput("first_pc", instr_pc, pc_reset_v);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, 0, 0);
            checkOutput("throughput", {31'b0, instr_valid}, 32'd1);
        end

        // Backpressure for five cycles: PC must freeze, nothing lost afterwards.
        applyStimulus(1, 0, 0, 0);
        held_addr = imem_rdaddress;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0);
            checkOutput("stall_addr_hold", {19'b0, imem_rdaddress}, {19'b0, held_addr});
        end
        applyStimulus(1, 1, 0, 0);
        checkOutput("stall_addr_hold", {19'b0, imem_rdaddress}, {19'b0, held_addr});
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 0, 0);
            checkOutput("no_gap_after_stall", {31'b0, instr_valid}, 32'd1);
        end

        // Redirect into a full FIFO.
        repeat (3) applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 1, 32'h0000_0100);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("redirect_latency_low", {31'b0, instr_valid}, 32'd0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("redirect_latency_high", {31'b0, instr_valid}, 32'd1);
        checkOutput("redirect_pc", instr_pc, 32'h0000_0100);
        checkOutput("redirect_instr", instr, memword(13'd64));
        repeat (4) applyStimulus(1, 1, 0, 0);

        // Misaligned redirect while a pop is happening in the same cycle.
        applyStimulus(1, 1, 1, 32'h0000_0103);
        repeat (2) applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("redirect_misaligned_pc", instr_pc, 32'h0000_0100);
        repeat (3) applyStimulus(1, 1, 0, 0);

        // fetch_en low for three cycles.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("fetch_off_gap", {31'b0, instr_valid}, 32'd0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("fetch_off_gap", {31'b0, instr_valid}, 32'd0);
        repeat (6) applyStimulus(1, 1, 0, 0);

        // Word-address wrap of the read port.
        applyStimulus(1, 1, 1, 32'h0000_7FF8);
        applyStimulus(1, 1, 0, 0);
        checkOutput("wrap_addr0", {19'b0, imem_rdaddress}, 32'h0000_1FFE);
        applyStimulus(1, 1, 0, 0);
        checkOutput("wrap_addr1", {19'b0, imem_rdaddress}, 32'h0000_1FFF);
        applyStimulus(1, 1, 0, 0);
        checkOutput("wrap_addr2", {19'b0, imem_rdaddress}, 32'h0000_0000);
        repeat (5) applyStimulus(1, 1, 0, 0);

        // 32-bit PC wrap.
        applyStimulus(1, 1, 1, 32'hFFFF_FFF8);
        repeat (8) applyStimulus(1, 1, 0, 0);

        // Asynchronous reset with the FIFO full.
        repeat (4) applyStimulus(1, 0, 0, 0);
        @(negedge clock);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("async_reset_instr", instr, 32'd0);
        checkOutput("async_reset_pc", instr_pc, 32'd0);
        checkOutput("async_reset_addr", {19'b0, imem_rdaddress},
                    {19'b0, pc_reset_v[IMEM_AW+1:2]});
        clearModel();
        repeat (2) @(negedge clock);
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        rst_n       = 1'b1;
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("refetch_pc", instr_pc, pc_reset_v);
        repeat (4) applyStimulus(1, 1, 0, 0);

        // Random traffic against the program-order model.
        for (int i = 0; i < 1500; i++) begin
            en  = ($urandom_range(0, 99) < 85);
            rdy = ($urandom_range(0, 99) < 70);
            rv  = ($urandom_range(0, 99) < 3);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                              : $urandom;
            applyStimulus(en, rdy, rv, rpc);
        end

        // Bounded liveness: the stream must recover once conditions are friendly.
        start = deliveries;
        for (int i = 0; i < 60 && (deliveries - start) < 10; i++) begin
            applyStimulus(1, 1, 0, 0);
        end
        checkOutput("liveness", {31'b0, (deliveries - start) >= 10}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
